// File: rtl/switch_count_ctrl.sv
// Switch front end for the 7-segment path: debounces four switches into press
// commands and keeps an 8-bit display value stepped manually or by a timed tick.
module switch_count_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int AUTO_TICK_CYCLES = 25000000,
  parameter int WRAP_MAX         = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_switch_1,
  input  logic       i_switch_2,
  input  logic       i_switch_3,
  input  logic       i_switch_4,
  output logic [7:0] o_value,
  output logic       o_update,
  output logic [1:0] o_mode
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TK_W = $clog2(AUTO_TICK_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(AUTO_TICK_CYCLES - 1);
  localparam logic [7:0]      WRAP    = 8'(WRAP_MAX);

  typedef enum logic [1:0] {
    MODE_MANUAL    = 2'd0,
    MODE_AUTO_UP   = 2'd1,
    MODE_AUTO_DOWN = 2'd2
  } mode_e;

  // Bit order everywhere: [0]=increment, [1]=decrement, [2]=mode, [3]=clear
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_deb;
  logic [3:0] r_deb_d;
  logic [3:0] r_press;

  mode_e            r_mode;
  mode_e            w_mode_next;
  logic             w_auto_up;
  logic             w_auto_dn;
  logic [TK_W-1:0]  r_tick_cnt;
  logic             w_tick;
  logic [7:0]       r_value;
  logic [7:0]       w_value_next;
  logic [7:0]       w_value_inc;
  logic [7:0]       w_value_dec;
  logic             r_update;

  assign w_raw = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb_d <= '0;
      r_press <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= w_deb;
      r_press <= w_deb & ~r_deb_d;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples
  for (genvar g = 0; g < 4; g++) begin : g_debounce
    logic [DB_W-1:0] r_cnt;
    logic            r_lvl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync2[g] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt <= '0;
        r_lvl <= r_sync2[g];
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end

    assign w_deb[g] = r_lvl;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_mode <= MODE_MANUAL;
    else          r_mode <= w_mode_next;
  end

  always_comb begin
    w_mode_next = r_mode;
    if (r_press[2]) begin
      case (r_mode)
        MODE_MANUAL:    w_mode_next = MODE_AUTO_UP;
        MODE_AUTO_UP:   w_mode_next = MODE_AUTO_DOWN;
        default:        w_mode_next = MODE_MANUAL;
      endcase
    end
  end

  always_comb begin
    o_mode    = r_mode;
    w_auto_up = (r_mode == MODE_AUTO_UP);
    w_auto_dn = (r_mode == MODE_AUTO_DOWN);
  end

  // Mode changes and clears restart the period so the first tick is a full period out
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (r_press[2] || r_press[3] || !(w_auto_up || w_auto_dn)) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TK_W'(1);
    end
  end

  assign w_tick      = (w_auto_up || w_auto_dn) && (r_tick_cnt == TK_LAST);
  assign w_value_inc = (r_value == WRAP) ? 8'd0 : r_value + 8'd1;
  assign w_value_dec = (r_value == 8'd0) ? WRAP : r_value - 8'd1;

  // A tick is dropped whenever any press lands in the same cycle
  always_comb begin
    w_value_next = r_value;
    if (r_press[3]) begin
      w_value_next = 8'd0;
    end else if (r_press[0] && !r_press[1]) begin
      w_value_next = w_value_inc;
    end else if (r_press[1] && !r_press[0]) begin
      w_value_next = w_value_dec;
    end else if ((r_press == 4'b0000) && w_tick) begin
      w_value_next = w_auto_up ? w_value_inc : w_value_dec;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value  <= 8'd0;
      r_update <= 1'b0;
    end else begin
      r_value  <= w_value_next;
      r_update <= (w_value_next != r_value);
    end
  end

  assign o_value  = r_value;
  assign o_update = r_update;

endmodule

// File: tb/tb_switch_count_ctrl.sv
// Randomized bench for switch_count_ctrl: every cycle the outputs are compared
// against a reference model built from sample histories and tick arithmetic.
module tb_switch_count_ctrl;

  localparam int D = 4;
  localparam int T = 8;
  localparam int W = 9;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_switch_1 = 1'b0;
  logic       i_switch_2 = 1'b0;
  logic       i_switch_3 = 1'b0;
  logic       i_switch_4 = 1'b0;
  logic [7:0] o_value;
  logic       o_update;
  logic [1:0] o_mode;

  int total = 0;
  int bad = 0;

  switch_count_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .AUTO_TICK_CYCLES(T),
    .WRAP_MAX        (W)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_switch_1(i_switch_1),
    .i_switch_2(i_switch_2),
    .i_switch_3(i_switch_3),
    .i_switch_4(i_switch_4),
    .o_value   (o_value),
    .o_update  (o_update),
    .o_mode    (o_mode)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a level is accepted when the last D samples (seen two
  // edges late) all disagree with it; ticks fall on multiples of T after the
  // last mode change or clear.
  logic [D+1:0] mHist [4];
  logic [3:0]   mDeb;
  logic [3:0]   mDebOld;
  logic [3:0]   mPress;
  int           mValue;
  int           mMode;
  int           mUpdate;
  int           mEdge;
  int           mBase;

  always @(posedge i_clk or negedge i_rst_n) begin : model
    logic [3:0] raw;
    logic [3:0] pu;
    int         nextVal;
    bit         tick;
    if (!i_rst_n) begin
      for (int s = 0; s < 4; s++) mHist[s] = '0;
      mDeb = '0; mDebOld = '0; mPress = '0;
      mValue = 0; mMode = 0; mUpdate = 0; mEdge = 0; mBase = 0;
    end else begin
      raw  = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};
      pu   = mPress;
      tick = (mMode != 0) && (mEdge > mBase) && (((mEdge - mBase) % T) == 0);
      nextVal = mValue;
      if (pu[3])                    nextVal = 0;
      else if (pu[0] && !pu[1])     nextVal = (mValue + 1) % (W + 1);
      else if (pu[1] && !pu[0])     nextVal = (mValue + W) % (W + 1);
      else if (pu == 4'b0000 && tick)
        nextVal = (mMode == 1) ? (mValue + 1) % (W + 1) : (mValue + W) % (W + 1);
      mUpdate = (nextVal != mValue) ? 1 : 0;
      mValue  = nextVal;
      if (pu[2]) begin
        mMode = (mMode + 1) % 3;
        mBase = mEdge;
      end
      if (pu[3]) mBase = mEdge;
      mPress  = mDeb & ~mDebOld;
      mDebOld = mDeb;
      for (int s = 0; s < 4; s++) begin
        mHist[s] = {mHist[s][D:0], raw[s]};
        if (mHist[s][D+1:2] == {D{~mDeb[s]}}) mDeb[s] = ~mDeb[s];
      end
      mEdge++;
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("value", o_value, 8'(mValue));
    checkOutput("update", {7'd0, o_update}, 8'(mUpdate));
    checkOutput("mode", {6'd0, o_mode}, 8'(mMode));
  endtask

  task automatic applyStimulus(input logic [3:0] sw, input int n);
    repeat (n) begin
      @(negedge i_clk);
      {i_switch_4, i_switch_3, i_switch_2, i_switch_1} = sw;
      @(posedge i_clk);
      #1;
      checkModel();
    end
  endtask

  task automatic applyRandom(input int n);
    int holdLeft [4];
    int prob [4];
    logic [3:0] sw;
    prob = '{40, 40, 15, 8};
    holdLeft = '{0, 0, 0, 0};
    sw = '0;
    repeat (n) begin
      for (int s = 0; s < 4; s++) begin
        if (holdLeft[s] == 0) begin
          sw[s] = ($urandom_range(0, 99) < prob[s]);
          holdLeft[s] = $urandom_range(1, 10);
        end
        holdLeft[s]--;
      end
      applyStimulus(sw, 1);
    end
  endtask

  task automatic press(input logic [3:0] sw);
    applyStimulus(sw, 5);
    applyStimulus(4'b0000, 12);
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_value", o_value, 8'd0);
    checkOutput("reset_update", {7'd0, o_update}, 8'd0);
    checkOutput("reset_mode", {6'd0, o_mode}, 8'd0);
    checkModel();
    @(negedge i_clk);
    i_rst_n = 1'b1;

    $display("[TB] debounce latency and held switch");
    applyStimulus(4'b0001, 60);
    applyStimulus(4'b0000, 12);
    checkOutput("held_once", o_value, 8'd1);

    $display("[TB] glitch rejection");
    press(4'b1000);
    checkOutput("clear", o_value, 8'd0);
    applyStimulus(4'b0010, 3);
    applyStimulus(4'b0000, 12);
    checkOutput("glitch", o_value, 8'd0);
    applyStimulus(4'b0010, 4);
    applyStimulus(4'b0000, 12);
    checkOutput("dec_wrap", o_value, 8'd9);

    $display("[TB] wrap");
    press(4'b1000);
    for (int i = 0; i < 10; i++) press(4'b0001);
    checkOutput("inc_wrap", o_value, 8'd0);
    press(4'b0010);
    checkOutput("dec_wrap2", o_value, 8'd9);

    $display("[TB] auto modes");
    applyStimulus(4'b0100, 5);
    applyStimulus(4'b0000, 40);
    checkOutput("mode_up", {6'd0, o_mode}, 8'd1);
    applyStimulus(4'b0100, 5);
    applyStimulus(4'b0000, 40);
    checkOutput("mode_down", {6'd0, o_mode}, 8'd2);
    applyStimulus(4'b0100, 5);
    applyStimulus(4'b0000, 30);
    checkOutput("mode_manual", {6'd0, o_mode}, 8'd0);

    $display("[TB] priority");
    press(4'b1000);
    for (int i = 0; i < 5; i++) press(4'b0001);
    checkOutput("set_five", o_value, 8'd5);
    press(4'b1011);
    checkOutput("clear_wins", o_value, 8'd0);
    for (int i = 0; i < 5; i++) press(4'b0001);
    press(4'b0011);
    checkOutput("inc_dec_cancel", o_value, 8'd5);

    $display("[TB] random traffic");
    applyRandom(3000);

    $display("[TB] async reset mid-operation");
    press(4'b1000);
    for (int i = 0; i < 7; i++) press(4'b0001);
    applyStimulus(4'b0100, 5);
    applyStimulus(4'b0000, 10);
    applyStimulus(4'b0001, 2);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    checkOutput("async_value", o_value, 8'd0);
    checkOutput("async_update", {7'd0, o_update}, 8'd0);
    checkOutput("async_mode", {6'd0, o_mode}, 8'd0);
    @(negedge i_clk);
    {i_switch_4, i_switch_3, i_switch_2, i_switch_1} = 4'b0000;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus(4'b0000, 30);
    checkOutput("no_stale", o_value, 8'd0);

    $display("[TB] switch held through reset release");
    @(negedge i_clk);
    i_rst_n = 1'b0;
    {i_switch_4, i_switch_3, i_switch_2, i_switch_1} = 4'b0001;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus(4'b0001, 20);
    checkOutput("held_release", o_value, 8'd1);
    applyRandom(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
